// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : pipe_pkg                                                   |
// | Description : Shared types and constants for the pipeline hazard and     |
// |               forwarding controller.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Hazard FSM state encoding
  typedef logic [1:0] hz_state_t;
  localparam hz_state_t ST_RUN      = 2'd0;
  localparam hz_state_t ST_LU_HOLD  = 2'd1;
  localparam hz_state_t ST_MDU_WAIT = 2'd2;

  // Width of the load-use bubble counter (covers LU_CYCLES up to 7)
  localparam int CNT_W = 3;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : pipe_hazard_ctrl_if                                        |
// | Description : Bundle between the pipeline registers (master) and the     |
// |               hazard controller (slave).                                 |
// |   master -> slave : ID/EX/MEM/WB register ids and write enables,         |
// |                     ex_redirect, ex_mdu_start, mdu_done                  |
// |   slave -> master : stall_if/id/ex, flush_ifid/idex/exmem, fwd_a/b,      |
// |                     perf_stall_cycles, perf_redirects                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic              idex_mem_read;
  logic              idex_reg_write;
  logic [REG_AW-1:0] idex_rd;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic              ex_redirect;
  logic              ex_mdu_start;
  logic              mdu_done;

  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [PERF_W-1:0] perf_stall_cycles;
  logic [PERF_W-1:0] perf_redirects;

  modport master (
    output id_rs1, id_rs2, idex_rs1, idex_rs2, idex_mem_read, idex_reg_write,
           idex_rd, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
           ex_redirect, ex_mdu_start, mdu_done,
    input  stall_if, stall_id, stall_ex, flush_ifid, flush_idex, flush_exmem,
           fwd_a, fwd_b, perf_stall_cycles, perf_redirects
  );

  modport slave (
    input  id_rs1, id_rs2, idex_rs1, idex_rs2, idex_mem_read, idex_reg_write,
           idex_rd, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
           ex_redirect, ex_mdu_start, mdu_done,
    output stall_if, stall_id, stall_ex, flush_ifid, flush_idex, flush_exmem,
           fwd_a, fwd_b, perf_stall_cycles, perf_redirects
  );
endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sat_counter                                                |
// | Description : Up-counter that sticks at all-ones instead of wrapping.    |
// |   clk : clock, rising edge        rst : synchronous active-high reset    |
// |   inc : count enable              q   : current count                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                           |
// | Description : Hazard/forwarding controller for a 5-stage in-order RV32   |
// |               pipeline: EX operand forwarding selects, load-use and RAW  |
// |               stalls, branch redirect flushes, multi-cycle MDU stall and |
// |               saturating performance counters.                           |
// |   clk  : clock, rising edge                                              |
// |   rst  : synchronous active-high reset                                   |
// |   bus  : pipe_hazard_ctrl_if.slave (hazard inputs, stall/flush/fwd and   |
// |          counter outputs)                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int LU_CYCLES = 1,
  parameter int MDU_EN    = 1,
  parameter int PERF_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] c_lu_reload = CNT_W'(LU_CYCLES - 1);
  localparam logic             c_mdu_on    = (MDU_EN != 0);
  localparam logic             c_lu_multi  = (LU_CYCLES > 1);

  // x0 is never a real producer, so it never matches
  function automatic logic reg_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  logic lu;
  logic raw;
  logic mdu_go;

  always_comb begin
    lu = bus.idex_mem_read &&
         (reg_match(bus.idex_rd, bus.id_rs1) || reg_match(bus.idex_rd, bus.id_rs2));
    // A start that completes in the same cycle costs no bubble
    mdu_go = c_mdu_on && bus.ex_mdu_start && !bus.mdu_done;
  end

  generate
    if (FWD_EN != 0) begin : g_fwd_on
      function automatic fwd_sel_t fwd_pick(input logic              exmem_we,
                                            input logic [REG_AW-1:0] exmem_rd,
                                            input logic              memwb_we,
                                            input logic [REG_AW-1:0] memwb_rd,
                                            input logic [REG_AW-1:0] rs);
        // The younger EX/MEM value takes precedence over MEM/WB
        if (exmem_we && reg_match(exmem_rd, rs)) begin
          return FWD_EXMEM;
        end else if (memwb_we && reg_match(memwb_rd, rs)) begin
          return FWD_MEMWB;
        end
        return FWD_RF;
      endfunction

      assign bus.fwd_a = fwd_pick(bus.exmem_reg_write, bus.exmem_rd,
                                  bus.memwb_reg_write, bus.memwb_rd, bus.idex_rs1);
      assign bus.fwd_b = fwd_pick(bus.exmem_reg_write, bus.exmem_rd,
                                  bus.memwb_reg_write, bus.memwb_rd, bus.idex_rs2);
      assign raw = 1'b0;
    end else begin : g_fwd_off
      assign bus.fwd_a = FWD_RF;
      assign bus.fwd_b = FWD_RF;
      // WB producers are covered by the regfile write-through bypass
      assign raw = (bus.idex_reg_write &&
                    (reg_match(bus.idex_rd, bus.id_rs1) ||
                     reg_match(bus.idex_rd, bus.id_rs2))) ||
                   (bus.exmem_reg_write &&
                    (reg_match(bus.exmem_rd, bus.id_rs1) ||
                     reg_match(bus.exmem_rd, bus.id_rs2)));
    end
  endgenerate

  hz_state_t        state_q;
  hz_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic stall_if;
  logic stall_id;
  logic stall_ex;
  logic flush_ifid;
  logic flush_idex;
  logic flush_exmem;
  logic redirect_evt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    flush_exmem  = 1'b0;
    redirect_evt = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.ex_redirect) begin
          // Wrong-path instructions in IF/ID and ID/EX are squashed; any
          // hazard they carried vanishes with them.
          flush_ifid   = 1'b1;
          flush_idex   = 1'b1;
          redirect_evt = 1'b1;
        end else if (mdu_go) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          stall_ex    = 1'b1;
          flush_exmem = 1'b1;
          state_d     = ST_MDU_WAIT;
        end else if (lu || raw) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_idex = 1'b1;
          // First bubble is inserted here; the remaining ones in LU_HOLD
          if (lu && c_lu_multi) begin
            cnt_d   = c_lu_reload;
            state_d = ST_LU_HOLD;
          end
        end
      end

      ST_LU_HOLD: begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        flush_idex = 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_RUN;
        end
      end

      ST_MDU_WAIT: begin
        if (bus.mdu_done) begin
          state_d = ST_RUN;
        end else begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          stall_ex    = 1'b1;
          flush_exmem = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_if    = stall_if;
  assign bus.stall_id    = stall_id;
  assign bus.stall_ex    = stall_ex;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.flush_exmem = flush_exmem;

  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_redir_q;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_if),
    .q   (perf_stall_q)
  );

  sat_counter #(.W(PERF_W)) u_redir_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_evt),
    .q   (perf_redir_q)
  );

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_redirects    = perf_redir_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                        |
// | Description : Self-checking bench. Instance A: forwarding on, 3-cycle    |
// |               load-use, 4-bit counters. Instance B: forwarding off,      |
// |               1-cycle load-use, 32-bit counters. Both see the same       |
// |               stimulus.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] idex_rs1;
    logic [4:0] idex_rs2;
    logic       idex_mem_read;
    logic       idex_reg_write;
    logic [4:0] idex_rd;
    logic       exmem_reg_write;
    logic [4:0] exmem_rd;
    logic       memwb_reg_write;
    logic [4:0] memwb_rd;
    logic       ex_redirect;
    logic       ex_mdu_start;
    logic       mdu_done;
  } stim_t;

  // ctrl = {stall_if, stall_id, stall_ex, flush_ifid, flush_idex, flush_exmem}
  typedef struct {
    stim_t      in;
    logic [5:0] a_ctrl;
    logic [1:0] a_fa;
    logic [1:0] a_fb;
    logic [5:0] b_ctrl;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t stim = '0;
  int    total = 0;
  int    bad   = 0;
  vec_t  vq[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(4))  if_a ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(32)) if_b ();

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .LU_CYCLES(3), .MDU_EN(1), .PERF_W(4))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .LU_CYCLES(1), .MDU_EN(1), .PERF_W(32))
    u_b (.clk(clk), .rst(rst), .bus(if_b));

  always_comb begin
    if_a.id_rs1 = stim.id_rs1;                   if_b.id_rs1 = stim.id_rs1;
    if_a.id_rs2 = stim.id_rs2;                   if_b.id_rs2 = stim.id_rs2;
    if_a.idex_rs1 = stim.idex_rs1;               if_b.idex_rs1 = stim.idex_rs1;
    if_a.idex_rs2 = stim.idex_rs2;               if_b.idex_rs2 = stim.idex_rs2;
    if_a.idex_mem_read = stim.idex_mem_read;     if_b.idex_mem_read = stim.idex_mem_read;
    if_a.idex_reg_write = stim.idex_reg_write;   if_b.idex_reg_write = stim.idex_reg_write;
    if_a.idex_rd = stim.idex_rd;                 if_b.idex_rd = stim.idex_rd;
    if_a.exmem_reg_write = stim.exmem_reg_write; if_b.exmem_reg_write = stim.exmem_reg_write;
    if_a.exmem_rd = stim.exmem_rd;               if_b.exmem_rd = stim.exmem_rd;
    if_a.memwb_reg_write = stim.memwb_reg_write; if_b.memwb_reg_write = stim.memwb_reg_write;
    if_a.memwb_rd = stim.memwb_rd;               if_b.memwb_rd = stim.memwb_rd;
    if_a.ex_redirect = stim.ex_redirect;         if_b.ex_redirect = stim.ex_redirect;
    if_a.ex_mdu_start = stim.ex_mdu_start;       if_b.ex_mdu_start = stim.ex_mdu_start;
    if_a.mdu_done = stim.mdu_done;               if_b.mdu_done = stim.mdu_done;
  end

  wire [5:0] a_ctrl = {if_a.stall_if, if_a.stall_id, if_a.stall_ex,
                       if_a.flush_ifid, if_a.flush_idex, if_a.flush_exmem};
  wire [5:0] b_ctrl = {if_b.stall_if, if_b.stall_id, if_b.stall_ex,
                       if_b.flush_ifid, if_b.flush_idex, if_b.flush_exmem};

  // EX holds a bubble during LU_HOLD, so a redirect there is a stimulus error
  always @(posedge clk) begin
    if (!rst && (u_a.state_q == ST_LU_HOLD)) begin
      assert (!stim.ex_redirect) else $error("ex_redirect asserted in LU_HOLD");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input stim_t s, input logic [5:0] ac, input logic [1:0] fa,
                     input logic [1:0] fb, input logic [5:0] bc);
    vec_t v;
    v.in = s; v.a_ctrl = ac; v.a_fa = fa; v.a_fb = fb; v.b_ctrl = bc;
    vq.push_back(v);
  endtask

  initial begin
    stim_t s;

    // ---------------- RUN-state decode table ----------------
    s = '0;                                                                       add(s, 6'b000000, 2'b00, 2'b00, 6'b000000);
    s = '0; s.id_rs1 = 1; s.id_rs2 = 2; s.idex_rs1 = 5; s.idex_rs2 = 0;
    s.exmem_reg_write = 1; s.exmem_rd = 5; s.memwb_reg_write = 1; s.memwb_rd = 5; add(s, 6'b000000, 2'b01, 2'b00, 6'b000000);
    s = '0; s.id_rs1 = 6; s.idex_rs1 = 6; s.idex_rs2 = 6;
    s.memwb_reg_write = 1; s.memwb_rd = 6;                                       add(s, 6'b000000, 2'b10, 2'b10, 6'b000000);
    s = '0; s.exmem_reg_write = 1; s.memwb_reg_write = 1; s.idex_reg_write = 1;   add(s, 6'b000000, 2'b00, 2'b00, 6'b000000);
    s = '0; s.idex_rs1 = 5; s.exmem_rd = 5; s.memwb_reg_write = 1; s.memwb_rd = 5; add(s, 6'b000000, 2'b10, 2'b00, 6'b000000);
    s = '0; s.id_rs1 = 3; s.idex_reg_write = 1; s.idex_rd = 3;                    add(s, 6'b000000, 2'b00, 2'b00, 6'b110010);
    s = '0; s.id_rs2 = 3; s.exmem_reg_write = 1; s.exmem_rd = 3;                  add(s, 6'b000000, 2'b00, 2'b00, 6'b110010);
    s = '0; s.id_rs2 = 7; s.idex_mem_read = 1; s.idex_reg_write = 1; s.idex_rd = 7; add(s, 6'b110010, 2'b00, 2'b00, 6'b110010);
    s.ex_redirect = 1;                                                            add(s, 6'b000110, 2'b00, 2'b00, 6'b000110);
    s = '0; s.ex_mdu_start = 1;                                                   add(s, 6'b111001, 2'b00, 2'b00, 6'b111001);
    s.mdu_done = 1;                                                               add(s, 6'b000000, 2'b00, 2'b00, 6'b000000);
    s = '0; s.ex_mdu_start = 1; s.id_rs1 = 7; s.idex_mem_read = 1; s.idex_rd = 7; add(s, 6'b111001, 2'b00, 2'b00, 6'b111001);
    s.ex_redirect = 1;                                                            add(s, 6'b000110, 2'b00, 2'b00, 6'b000110);
    s = '0; s.idex_mem_read = 1; s.idex_reg_write = 1;                            add(s, 6'b000000, 2'b00, 2'b00, 6'b000000);
    s = '0; s.id_rs1 = 8; s.idex_mem_read = 1; s.idex_reg_write = 1; s.idex_rd = 7; add(s, 6'b000000, 2'b00, 2'b00, 6'b000000);

    // Reset is held through the table so both FSMs stay in RUN and every
    // row checks the RUN-state decode on its own.
    rst = 1'b1;
    tick();
    foreach (vq[i]) begin
      stim = vq[i].in;
      @(negedge clk);
      chk($sformatf("row%0d a_ctrl", i), 32'(a_ctrl), 32'(vq[i].a_ctrl));
      chk($sformatf("row%0d a_fwd_a", i), 32'(if_a.fwd_a), 32'(vq[i].a_fa));
      chk($sformatf("row%0d a_fwd_b", i), 32'(if_a.fwd_b), 32'(vq[i].a_fb));
      chk($sformatf("row%0d b_ctrl", i), 32'(b_ctrl), 32'(vq[i].b_ctrl));
      chk($sformatf("row%0d b_fwd", i), 32'({if_b.fwd_a, if_b.fwd_b}), 32'd0);
      tick();
    end
    stim = '0;
    @(negedge clk);
    chk("reset a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd0);
    chk("reset b_perf_redir", if_b.perf_redirects, 32'd0);

    // ---------------- load-use, LU_CYCLES=3 ----------------
    tick();
    rst = 1'b0;
    stim = '0; stim.id_rs2 = 7; stim.idex_mem_read = 1; stim.idex_reg_write = 1; stim.idex_rd = 7;
    @(negedge clk);
    chk("lu c0 a_ctrl", 32'(a_ctrl), 32'b110010);
    chk("lu c0 b_ctrl", 32'(b_ctrl), 32'b110010);
    tick();
    stim = '0; stim.id_rs2 = 7;   // load left EX, a bubble replaced it
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("lu c%0d a_ctrl", c), 32'(a_ctrl), (c < 3) ? 32'b110010 : 32'b000000);
      chk($sformatf("lu c%0d b_ctrl", c), 32'(b_ctrl), 32'b000000);
      if (c < 3) tick();
    end
    chk("lu a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd3);
    chk("lu b_perf_stall", if_b.perf_stall_cycles, 32'd1);

    // ---------------- redirect beats load-use ----------------
    tick();
    stim = '0; stim.id_rs2 = 7; stim.idex_mem_read = 1; stim.idex_reg_write = 1;
    stim.idex_rd = 7; stim.ex_redirect = 1;
    @(negedge clk);
    chk("redir a_ctrl", 32'(a_ctrl), 32'b000110);
    chk("redir b_ctrl", 32'(b_ctrl), 32'b000110);
    tick();
    stim = '0;
    @(negedge clk);
    chk("redir a_perf_redir", 32'(if_a.perf_redirects), 32'd1);
    chk("redir b_perf_redir", if_b.perf_redirects, 32'd1);
    chk("redir a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd3);

    // ---------------- MDU: start t0, done t4 ----------------
    for (int t = 0; t <= 5; t++) begin
      tick();
      stim = '0; stim.ex_mdu_start = (t <= 4); stim.mdu_done = (t == 4);
      @(negedge clk);
      chk($sformatf("mdu t%0d a_ctrl", t), 32'(a_ctrl), (t < 4) ? 32'b111001 : 32'b000000);
      chk($sformatf("mdu t%0d b_stall_ex", t), 32'(if_b.stall_ex), (t < 4) ? 32'd1 : 32'd0);
    end
    chk("mdu a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd7);
    chk("mdu b_perf_stall", if_b.perf_stall_cycles, 32'd5);
    tick();
    stim = '0; stim.ex_mdu_start = 1; stim.mdu_done = 1;
    @(negedge clk);
    chk("mdu same-cycle a_ctrl", 32'(a_ctrl), 32'b000000);
    tick();
    stim = '0;
    @(negedge clk);
    chk("mdu same-cycle after a_ctrl", 32'(a_ctrl), 32'b000000);
    chk("mdu same-cycle a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd7);

    // ---------------- no-forwarding RAW walk: EX, MEM, WB ----------------
    tick();
    stim = '0; stim.id_rs1 = 3; stim.idex_reg_write = 1; stim.idex_rd = 3;
    @(negedge clk);
    chk("raw ex b_ctrl", 32'(b_ctrl), 32'b110010);
    chk("raw ex a_ctrl", 32'(a_ctrl), 32'b000000);
    tick();
    stim = '0; stim.id_rs1 = 3; stim.exmem_reg_write = 1; stim.exmem_rd = 3;
    @(negedge clk);
    chk("raw mem b_ctrl", 32'(b_ctrl), 32'b110010);
    tick();
    stim = '0; stim.id_rs1 = 3; stim.memwb_reg_write = 1; stim.memwb_rd = 3;
    @(negedge clk);
    chk("raw wb b_ctrl", 32'(b_ctrl), 32'b000000);
    chk("raw b_perf_stall", if_b.perf_stall_cycles, 32'd7);

    // ---------------- reset during MDU_WAIT ----------------
    tick();
    stim = '0; stim.ex_mdu_start = 1;
    tick();                    // MDU_WAIT cycle 1
    tick();                    // MDU_WAIT cycle 2
    @(negedge clk);
    chk("rst mdu_wait a_stall_ex", 32'(if_a.stall_ex), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stim = '0;
    @(negedge clk);
    chk("rst a_ctrl", 32'(a_ctrl), 32'b000000);
    chk("rst b_ctrl", 32'(b_ctrl), 32'b000000);
    chk("rst a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd0);
    chk("rst a_perf_redir", 32'(if_a.perf_redirects), 32'd0);
    chk("rst b_perf_stall", if_b.perf_stall_cycles, 32'd0);

    // ---------------- saturation: 20+ stall cycles ----------------
    tick();
    stim = '0; stim.ex_mdu_start = 1;
    for (int c = 0; c < 20; c++) tick();
    @(negedge clk);
    chk("sat 20 a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd15);
    chk("sat 20 b_perf_stall", if_b.perf_stall_cycles, 32'd20);
    tick();
    @(negedge clk);
    chk("sat 21 a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd15);
    chk("sat 21 b_perf_stall", if_b.perf_stall_cycles, 32'd21);
    tick();
    stim.mdu_done = 1;
    @(negedge clk);
    chk("sat done a_ctrl", 32'(a_ctrl), 32'b000000);
    tick();
    stim = '0;
    @(negedge clk);
    chk("sat end a_perf_stall", 32'(if_a.perf_stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
